// File: rtl/noc_packetizer.sv
// Message-to-flit packetizer: one accepted message becomes a HEADER flit, zero or
// more DATA flits and one TAIL flit on a registered valid/ready flit stream.
module noc_packetizer #(
  parameter int FLIT_DATA_WIDTH   = 32,
  parameter int MESH_ADDR_X       = 2,
  parameter int MESH_ADDR_Y       = 2,
  parameter int MAX_FLITS         = 8,
  parameter int TAIL_LENGTH_WIDTH = $clog2(FLIT_DATA_WIDTH + 1),
  parameter int LEN_WIDTH         = $clog2(MAX_FLITS * FLIT_DATA_WIDTH + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [MESH_ADDR_X-1:0]             in_dst_x,
  input  logic [MESH_ADDR_Y-1:0]             in_dst_y,
  input  logic [LEN_WIDTH-1:0]               in_len,
  input  logic [MAX_FLITS*FLIT_DATA_WIDTH-1:0] in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [FLIT_DATA_WIDTH+1:0]         out_flit,
  output logic                               len_err
);

  localparam int W       = FLIT_DATA_WIDTH;
  localparam int TLW     = TAIL_LENGTH_WIDTH;
  localparam int MAX_LEN = MAX_FLITS * W;
  localparam int CW      = $clog2(MAX_FLITS + 1);

  localparam logic [1:0] HEADER = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] TAIL   = 2'd2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HDR  = 2'd1;
  localparam logic [1:0] BODY = 2'd2;

  if (MESH_ADDR_X + MESH_ADDR_Y + TAIL_LENGTH_WIDTH > FLIT_DATA_WIDTH) begin : g_bad_header
    $error("noc_packetizer: header fields do not fit in FLIT_DATA_WIDTH");
  end
  if (MAX_FLITS < 1) begin : g_bad_max_flits
    $error("noc_packetizer: MAX_FLITS must be at least 1");
  end

  logic [1:0]         state;
  logic [CW-1:0]      k_q;
  logic [CW-1:0]      n_q;
  logic [TLW-1:0]     tl_q;
  logic [MAX_LEN-1:0] data_q;

  logic [LEN_WIDTH-1:0] len_c;
  int                   n_int;
  logic [CW-1:0]        n_c;
  logic [TLW-1:0]       tl_c;
  logic [W+1:0]         hdr_c;
  logic                 too_long;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; a flit offered with out_valid stays unchanged until that edge.
  assign in_ready = (state == IDLE);
  assign too_long = (32'(in_len) > MAX_LEN);

  always_comb begin
    len_c = in_len;
    if (too_long) len_c = LEN_WIDTH'(MAX_LEN);
    n_int = (32'(len_c) + W - 1) / W;
    if (len_c == '0) n_int = 1;
    n_c   = CW'(n_int);
    tl_c  = TLW'(32'(len_c) - (n_int - 1) * W);
    hdr_c = {HEADER, W'({in_dst_x, in_dst_y, tl_c})};
  end

  // Payload of body flit j; the last flit has bits at and above tl cleared.
  function automatic logic [W+1:0] body_flit(input logic [CW-1:0] j);
    logic [W-1:0] p;
    logic         last;
    last = (j == n_q - CW'(1));
    p    = W'(data_q >> (32'(j) * W));
    for (int i = 0; i < W; i++) begin
      if (last && (i >= int'(tl_q))) p[i] = 1'b0;
    end
    return {(last ? TAIL : DATA), p};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k_q       <= '0;
      n_q       <= '0;
      tl_q      <= '0;
      data_q    <= '0;
      out_valid <= 1'b0;
      out_flit  <= '0;
      len_err   <= 1'b0;
    end else begin
      len_err <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            state     <= HDR;
            data_q    <= in_data;
            n_q       <= n_c;
            tl_q      <= tl_c;
            k_q       <= '0;
            out_valid <= 1'b1;
            out_flit  <= hdr_c;
            len_err   <= too_long;
          end
        end
        HDR: begin
          if (out_ready) begin
            state    <= BODY;
            k_q      <= '0;
            out_flit <= body_flit('0);
          end
        end
        BODY: begin
          if (out_ready) begin
            if (k_q == n_q - CW'(1)) begin
              state     <= IDLE;
              k_q       <= '0;
              out_valid <= 1'b0;
            end else begin
              k_q      <= k_q + CW'(1);
              out_flit <= body_flit(k_q + CW'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_packetizer.sv
// Directed and backpressure bench for noc_packetizer at default parameters
// (W=32, 2-bit mesh addresses, MAX_FLITS=8, 6-bit tail length, 9-bit length).
module tb_noc_packetizer;

  localparam int W  = 32;
  localparam int MF = 8;
  localparam int LW = 9;
  localparam int DW = MF * W;
  localparam int FW = W + 2;

  // Clock and reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_dst_x;
  logic [1:0]    in_dst_y;
  logic [LW-1:0] in_len;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [FW-1:0] out_flit;
  logic          len_err;

  noc_packetizer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_dst_x  (in_dst_x),
    .in_dst_y  (in_dst_y),
    .in_len    (in_len),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_flit  (out_flit),
    .len_err   (len_err)
  );

  // Scoreboard
  int            checks = 0;
  int            errors = 0;
  logic [FW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: offer a message and return just after the accepting edge.
  task automatic send(input logic [1:0] x, input logic [1:0] y, input int len,
                      input logic [DW-1:0] d);
    in_dst_x = x;
    in_dst_y = y;
    in_len   = LW'(len);
    in_data  = d;
    in_valid = 1'b1;
    for (int c = 0; c < 100 && !in_ready; c++) tick();
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Reference packet model: expected flit sequence for one accepted message.
  function automatic void push_model(input logic [1:0] x, input logic [1:0] y,
                                     input int len, input logic [DW-1:0] d);
    int           l, n, tl;
    logic [W-1:0] p;
    l  = (len > DW) ? DW : len;
    n  = (l == 0) ? 1 : (l + W - 1) / W;
    tl = l - (n - 1) * W;
    exp_q.push_back({2'd0, 22'd0, x, y, 6'(tl)});
    for (int k = 0; k < n; k++) begin
      p = d[k*W +: W];
      if (k == n - 1) begin
        for (int i = tl; i < W; i++) p[i] = 1'b0;
        exp_q.push_back({2'd2, p});
      end else begin
        exp_q.push_back({2'd1, p});
      end
    end
  endfunction

  task automatic draw_msg();
    in_dst_x = 2'($urandom_range(0, 3));
    in_dst_y = 2'($urandom_range(0, 3));
    in_len   = LW'($urandom_range(0, 300));
    for (int i = 0; i < MF; i++) in_data[i*W +: W] = $urandom();
  endtask

  logic [DW-1:0] d;
  logic [FW-1:0] last_flit;
  logic [FW-1:0] e;
  logic          stalled;
  logic          accepted;
  int            sent;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_dst_x  = '0;
    in_dst_y  = '0;
    in_len    = '0;
    in_data   = '0;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_flit", 64'(out_flit), 64'd0);
    check("rst_len_err", 64'(len_err), 64'd0);
    rst = 1'b0;
    tick();

    // L=70 to (2,1): tl=6, two DATA flits, masked TAIL
    d = {128'h0, 32'hDEADBEEF, 32'hFFFFFFC5, 32'h9ABCDEF0, 32'h12345678};
    send(2'd2, 2'd1, 70, d);
    check("l70_hdr_valid", 64'(out_valid), 64'd1);
    check("l70_hdr", 64'(out_flit), 64'({2'd0, 32'h246}));
    check("l70_in_ready_busy", 64'(in_ready), 64'd0);
    check("l70_len_err", 64'(len_err), 64'd0);
    tick();
    check("l70_data0", 64'(out_flit), 64'({2'd1, 32'h12345678}));
    tick();
    check("l70_data1", 64'(out_flit), 64'({2'd1, 32'h9ABCDEF0}));
    tick();
    check("l70_tail", 64'(out_flit), 64'({2'd2, 32'h00000005}));
    tick();
    check("l70_done_valid", 64'(out_valid), 64'd0);
    check("l70_in_ready_back", 64'(in_ready), 64'd1);

    // L=64 to (1,3): tl=32, full TAIL word
    d = {160'h0, 32'hFFFFFFFF, 32'h5A5A0002, 32'hA5A50001};
    send(2'd1, 2'd3, 64, d);
    check("l64_hdr", 64'(out_flit), 64'({2'd0, 32'h1E0}));
    tick();
    check("l64_data0", 64'(out_flit), 64'({2'd1, 32'hA5A50001}));
    tick();
    check("l64_tail", 64'(out_flit), 64'({2'd2, 32'h5A5A0002}));
    tick();
    check("l64_done_valid", 64'(out_valid), 64'd0);

    // L=0 to (3,0): header plus an all-zero TAIL only
    d = {8{32'hCAFEF00D}};
    send(2'd3, 2'd0, 0, d);
    check("l0_hdr", 64'(out_flit), 64'({2'd0, 32'h300}));
    tick();
    check("l0_tail", 64'(out_flit), 64'({2'd2, 32'h0}));
    check("l0_tail_valid", 64'(out_valid), 64'd1);
    tick();
    check("l0_done_valid", 64'(out_valid), 64'd0);

    // L=300 to (0,2): clamped to 256, len_err pulse, 7 DATA + TAIL
    for (int i = 0; i < MF; i++) d[i*W +: W] = 32'h10000000 + 32'(i);
    send(2'd0, 2'd2, 300, d);
    check("l300_len_err", 64'(len_err), 64'd1);
    check("l300_hdr", 64'(out_flit), 64'({2'd0, 32'hA0}));
    tick();
    check("l300_len_err_clear", 64'(len_err), 64'd0);
    for (int i = 0; i < MF - 1; i++) begin
      check("l300_data", 64'(out_flit), 64'({2'd1, 32'h10000000 + 32'(i)}));
      tick();
    end
    check("l300_tail", 64'(out_flit), 64'({2'd2, 32'h10000007}));
    tick();
    check("l300_done_valid", 64'(out_valid), 64'd0);

    // Reset during the second DATA flit of L=96
    d = {160'h0, 32'h33333333, 32'h22222222, 32'h11111111};
    send(2'd2, 2'd2, 96, d);
    check("l96_hdr", 64'(out_flit), 64'({2'd0, 32'h2A0}));
    tick();
    check("l96_data0", 64'(out_flit), 64'({2'd1, 32'h11111111}));
    tick();
    check("l96_data1", 64'(out_flit), 64'({2'd1, 32'h22222222}));
    #1 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_out_flit", 64'(out_flit), 64'd0);
    #2 rst = 1'b0;
    tick();
    check("post_rst_out_valid", 64'(out_valid), 64'd0);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    d = {224'h0, 32'h77777777};
    send(2'd1, 2'd1, 32, d);
    check("post_rst_hdr", 64'(out_flit), 64'({2'd0, 32'h160}));
    tick();
    check("post_rst_tail", 64'(out_flit), 64'({2'd2, 32'h77777777}));
    tick();
    check("post_rst_done_valid", 64'(out_valid), 64'd0);

    // 100 random messages, in_valid held through busy periods, 50% backpressure
    sent    = 0;
    stalled = 1'b0;
    draw_msg();
    in_valid  = 1'b1;
    out_ready = 1'($urandom_range(0, 1));
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (out_valid && stalled) check("stall_stable", 64'(out_flit), 64'(last_flit));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_flit", 64'(out_valid), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("rand_flit", 64'(out_flit), 64'(e));
        end
      end
      accepted = in_valid && in_ready;
      if (accepted) push_model(in_dst_x, in_dst_y, int'(in_len), in_data);
      stalled   = out_valid && !out_ready;
      last_flit = out_flit;
      tick();
      if (accepted) begin
        sent++;
        if (sent < 100) draw_msg();
        else in_valid = 1'b0;
      end
      out_ready = 1'($urandom_range(0, 1));
      if (sent == 100 && exp_q.size() == 0 && !out_valid) break;
    end
    check("rand_sent", 64'(sent), 64'd100);
    check("rand_drained", 64'(exp_q.size()), 64'd0);
    check("rand_idle_valid", 64'(out_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
